// File: rtl/bd_flit_packer_pkg.sv
// Shared widths, state encoding and word-to-chunk selection for the BD flit packer.
package bd_flit_packer_pkg;

  localparam int FLIT_W   = 11;
  localparam int TAIL_BIT = 10;
  localparam int WORD_W   = 21;
  localparam int ROUTE_W  = 10;
  localparam int CHUNK_W  = 10;

  // HOLD_C: the held flit is committed to the wire; HOLD_W: it has gone, the word has not come yet.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_C0,
    ST_C1,
    ST_HOLD,
    ST_HOLD_C,
    ST_HOLD_W,
    ST_TAIL
  } state_e;

  typedef enum logic [1:0] {
    CH0,
    CH1,
    CH2
  } chunk_e;

  function automatic logic [CHUNK_W-1:0] chunk_sel(input logic [WORD_W-1:0] w, input chunk_e idx);
    logic [CHUNK_W-1:0] c;
    case (idx)
      CH0:     c = w[9:0];
      CH1:     c = w[19:10];
      default: c = {9'b0, w[20]};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/bd_flit_packer_if.sv
// Word-in / flit-out handshake bundle; the packer uses the slave view, the environment the master view.
interface bd_flit_packer_if;
  import bd_flit_packer_pkg::*;

  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [FLIT_W-1:0] out_flit;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_flit, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_flit, out_valid
  );
endinterface

// File: rtl/bd_flit_packer.sv
// Packs BD words into routed flit packets: header, then three flits per word, with the
// last flit of each word held back until it is known whether it carries the tail.
module bd_flit_packer
  import bd_flit_packer_pkg::*;
#(
  parameter int MAX_WORDS    = 4,
  parameter int FLUSH_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ROUTE_W-1:0] route,
  bd_flit_packer_if.slave    bus,
  output logic               busy
);

  localparam logic [3:0] WCNT_MAX  = 4'(MAX_WORDS);
  localparam logic [7:0] IDLE_LAST = 8'(FLUSH_CYCLES - 1);

  state_e             state;
  logic [WORD_W-1:0]  word_q;
  logic [ROUTE_W-1:0] route_q;
  logic [3:0]         wcnt_q;
  logic [7:0]         idle_q;

  logic              in_ready;
  logic              out_valid;
  logic [FLIT_W-1:0] out_flit;
  logic              accept;
  logic              flit_done;

  assign accept    = bus.in_valid && in_ready;
  assign flit_done = out_valid && bus.out_ready;

  // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_flit  = '0;
    unique case (state)
      ST_IDLE: in_ready = 1'b1;
      ST_HDR: begin
        out_valid = 1'b1;
        out_flit  = {1'b0, route_q};
      end
      ST_C0: begin
        out_valid = 1'b1;
        out_flit  = {1'b0, chunk_sel(word_q, CH0)};
      end
      ST_C1: begin
        out_valid = 1'b1;
        out_flit  = {1'b0, chunk_sel(word_q, CH1)};
      end
      // Uncommitted: a waiting word is what makes the held flit a non-tail flit.
      ST_HOLD: begin
        out_flit = {1'b0, chunk_sel(word_q, CH2)};
        if (bus.in_valid) begin
          out_valid = 1'b1;
          in_ready  = bus.out_ready;
        end
      end
      ST_HOLD_C: begin
        out_valid = 1'b1;
        in_ready  = bus.out_ready;
        out_flit  = {1'b0, chunk_sel(word_q, CH2)};
      end
      ST_HOLD_W: in_ready = 1'b1;
      ST_TAIL: begin
        out_valid = 1'b1;
        out_flit  = {1'b1, chunk_sel(word_q, CH2)};
      end
      default: ;
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_flit  = out_flit;
  assign busy          = (state != ST_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      word_q  <= '0;
      route_q <= '0;
      wcnt_q  <= '0;
      idle_q  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: if (accept) begin
          word_q  <= bus.in_data;
          route_q <= route;
          wcnt_q  <= 4'd1;
          state   <= ST_HDR;
        end
        ST_HDR: if (flit_done) state <= ST_C0;
        ST_C0:  if (flit_done) state <= ST_C1;
        ST_C1: if (flit_done) begin
          if (wcnt_q == WCNT_MAX) begin
            state <= ST_TAIL;
          end else begin
            state  <= ST_HOLD;
            idle_q <= '0;
          end
        end
        ST_HOLD: begin
          if (accept) begin
            word_q <= bus.in_data;
            wcnt_q <= wcnt_q + 4'd1;
            state  <= ST_C0;
          end else if (bus.in_valid) begin
            state <= ST_HOLD_C;
          end else begin
            idle_q <= idle_q + 8'd1;
            if (idle_q == IDLE_LAST) state <= ST_TAIL;
          end
        end
        // Once committed the packet continues; the flush timer no longer applies.
        ST_HOLD_C: begin
          if (accept) begin
            word_q <= bus.in_data;
            wcnt_q <= wcnt_q + 4'd1;
            state  <= ST_C0;
          end else if (flit_done) begin
            state <= ST_HOLD_W;
          end
        end
        ST_HOLD_W: if (accept) begin
          word_q <= bus.in_data;
          wcnt_q <= wcnt_q + 4'd1;
          state  <= ST_C0;
        end
        ST_TAIL: if (flit_done) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bd_flit_packer.sv
// Directed bench for bd_flit_packer: expected flits are queued at stimulus time and a
// separate monitor pops and compares every accepted flit.
`timescale 1ns/1ps
module tb_bd_flit_packer;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] route = '0;
  logic       busy;
  int         ready_mode = 0;  // 0: always ready, 1: toggle each cycle, 2: never ready

  bd_flit_packer_if bus ();

  bd_flit_packer #(
    .MAX_WORDS    (4),
    .FLUSH_CYCLES (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .route (route),
    .bus   (bus.slave),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  logic [10:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic logic [9:0] chunk(input logic [20:0] w, input int i);
    if (i == 0) return w[9:0];
    if (i == 1) return w[19:10];
    return {9'b0, w[20]};
  endfunction

  task automatic expect_packet(input logic [9:0] r, input logic [20:0] ws[$]);
    exp_q.push_back({1'b0, r});
    foreach (ws[i]) begin
      exp_q.push_back({1'b0, chunk(ws[i], 0)});
      exp_q.push_back({1'b0, chunk(ws[i], 1)});
      exp_q.push_back({(i == ws.size() - 1) ? 1'b1 : 1'b0, chunk(ws[i], 2)});
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic send_word(input logic [20:0] d);
    bit acc;
    bit ok;
    ok = 1'b0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      #2;
      acc = bus.in_ready;
      @(negedge clk);
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    bus.in_valid = 1'b0;
    check("word_accept", 32'(ok), 32'd1);
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      #2;
      if (exp_q.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    check({name, "_drained"}, 32'(done), 32'd1);
    @(negedge clk);
  endtask

  // Sink: out_ready changes just after the falling edge.
  initial begin : ready_drv
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      #1;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ~bus.out_ready;
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: samples just before each rising edge; checks stall stability and flit order.
  initial begin : monitor
    logic        pend;
    logic [10:0] pend_flit;
    pend = 1'b0;
    pend_flit = '0;
    forever begin
      @(negedge clk);
      #3;
      if (reset) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          check("stall_valid", 32'(bus.out_valid), 32'd1);
          check("stall_flit", 32'(bus.out_flit), 32'(pend_flit));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_flit: got 0x%0h, expected none (t=%0t)", bus.out_flit, $time);
          end else begin
            check("flit", 32'(bus.out_flit), 32'(exp_q.pop_front()));
          end
          pend = 1'b0;
        end else if (bus.out_valid) begin
          pend      = 1'b1;
          pend_flit = bus.out_flit;
        end else begin
          pend = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [20:0] words[$];
    int          gaps;

    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // Reset state
    #1 reset = 1'b1;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_flit", 32'(bus.out_flit), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #2;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);

    // Single word closed by flush; route sampled only at accept
    route = 10'h3FC;
    words.delete();
    words.push_back(21'h1ABCDE);
    expect_packet(10'h3FC, words);
    send_word(21'h1ABCDE);
    route = 10'h155;
    #2;
    check("hdr_latency_valid", 32'(bus.out_valid), 32'd1);
    check("hdr_latency_flit", 32'(bus.out_flit), 32'h3FC);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    gaps = 0;
    for (int t = 0; t < 40; t++) begin
      #3;
      if (bus.out_valid) break;
      gaps++;
      @(negedge clk);
    end
    check("flush_idle_cycles", 32'(gaps), 32'd16);
    check("flush_tail_flit", 32'(bus.out_flit), 32'h401);
    @(negedge clk);
    drain("single");
    check("single_busy_low", 32'(busy), 32'd0);

    // Back-to-back MAX_WORDS packet with the newly set route
    words.delete();
    words.push_back(21'h1FFFFF);
    words.push_back(21'h000000);
    words.push_back(21'h012345);
    words.push_back(21'h0A5A5A);
    expect_packet(10'h155, words);
    foreach (words[i]) send_word(words[i]);
    bus.in_data  = 21'h1F0F0F;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 30; t++) begin
      #2;
      if (!busy) break;
      check("full_no_accept", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    drain("b2b");

    // Backpressure toggling across a two-word packet
    route = 10'h2A3;
    ready_mode = 1;
    words.delete();
    words.push_back(21'h0ABCD3);
    words.push_back(21'h1357AC);
    expect_packet(10'h2A3, words);
    foreach (words[i]) send_word(words[i]);
    drain("bp");
    ready_mode = 0;
    @(negedge clk);

    // HOLD commit: one-cycle in_valid pulse while the sink stalls
    route = 10'h0F0;
    words.delete();
    words.push_back(21'h100400);
    words.push_back(21'h0003FF);
    expect_packet(10'h0F0, words);
    send_word(21'h100400);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    ready_mode   = 2;
    bus.in_data  = 21'h0003FF;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2;
    check("commit_valid", 32'(bus.out_valid), 32'd1);
    check("commit_flit", 32'(bus.out_flit), 32'h001);
    check("commit_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    #2;
    check("commit_hold_valid", 32'(bus.out_valid), 32'd1);
    @(negedge clk);
    ready_mode = 0;
    @(negedge clk);
    #2;
    check("commit_wait_valid", 32'(bus.out_valid), 32'd0);
    check("commit_wait_busy", 32'(busy), 32'd1);
    @(negedge clk);
    send_word(21'h0003FF);
    drain("commit");

    // Reset while C1 is stalled: partial packet dropped, no tail
    route = 10'h3C3;
    exp_q.push_back({1'b0, 10'h3C3});
    exp_q.push_back({1'b0, chunk(21'h0F0F0F, 0)});
    ready_mode = 2;
    @(negedge clk);
    send_word(21'h0F0F0F);
    ready_mode = 0;
    @(negedge clk);
    @(negedge clk);
    ready_mode = 2;
    #2;
    check("pre_rst_c1_flit", 32'(bus.out_flit), 32'({1'b0, chunk(21'h0F0F0F, 1)}));
    #2 reset = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_out_flit", 32'(bus.out_flit), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    ready_mode = 0;
    #2;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("post_rst_dropped", 32'(exp_q.size()), 32'd0);
    @(negedge clk);

    // Fresh packet after reset begins with its header
    route = 10'h011;
    words.delete();
    words.push_back(21'h0C0FFE);
    expect_packet(10'h011, words);
    send_word(21'h0C0FFE);
    #2;
    check("post_rst_hdr", 32'(bus.out_flit), 32'h011);
    @(negedge clk);
    drain("post_rst");

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
